p_rr_1hot_arb: RTL and testbench

Round-robin arbiter that turns a request vector into a registered one-hot grant, presented to a downstream consumer over a valid/ready handshake. It is the producer side of one-hot vectors in the `p` primitive library: every `o_gnt` it emits is exactly one-hot whenever `o_gnt_vld` is high, and all-zero otherwise. It sits in front of shared resources such as a single write port or bus slot, where several clients compete and one winner per transaction is required.

---
 rtl/p_pkg.sv | 24 ++
 rtl/p_rr_1hot_pick.sv | 38 +++
 rtl/p_rr_1hot_arb.sv | 105 ++++++++++
 tb/tb_p_rr_1hot_arb.sv | 128 ++++++++++++
 4 files changed

// File: rtl/p_pkg.sv
// Shared definitions for the p primitive library: arbiter state encoding and
// a constant width helper for index signals.
package p_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        GNT  = 1'b1
    } p_arb_state_e;

    // Bits needed to hold an index in 0..n-1 (minimum 1).
    function automatic int p_clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/p_rr_1hot_pick.sv
// Combinational round-robin pick: first set request at or after i_ptr+1,
// wrapping, using a double-width rotate and a lowest-set-bit priority mask.
module p_rr_1hot_pick
    import p_pkg::*;
#(
    parameter  int W  = 4,
    localparam int IW = p_clog2(W)
) (
    input  logic [W-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [W-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    logic [2*W-1:0] dbl;
    logic [2*W-1:0] back;
    logic [W-1:0]   rot;
    logic [W-1:0]   low;
    int             start;

    always_comb begin
        start = (int'(i_ptr) >= W - 1) ? 0 : int'(i_ptr) + 1;
        // Rotate so the search start lands at bit 0, isolate the lowest set
        // bit, then rotate the one-hot back into requester positions.
        dbl   = {i_req, i_req} >> start;
        rot   = dbl[W-1:0];
        low   = rot & (~rot + W'(1));
        back  = {low, low} << start;
        o_gnt = back[2*W-1:W];
        o_any = |rot;
        o_idx = '0;
        for (int i = 0; i < W; i++) begin
            if (o_gnt[i]) o_idx = IW'(i);
        end
    end

endmodule

// File: rtl/p_rr_1hot_arb.sv
// Round-robin arbiter with registered one-hot grant over valid/ready.
// Optional grant lock enabled by defining P_RR_1HOT_ARB_LOCK_EN.
//
// state | meaning
// IDLE  | no grant presented
// GNT   | grant presented and held until accepted
module p_rr_1hot_arb
    import p_pkg::*;
#(
    parameter  int W  = 4,
    localparam int IW = p_clog2(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  i_req,
`ifdef P_RR_1HOT_ARB_LOCK_EN
    input  logic          i_lock,
`endif
    output logic          o_gnt_vld,
    input  logic          i_gnt_rdy,
    output logic [W-1:0]  o_gnt,
    output logic [IW-1:0] o_gnt_idx
);

    p_arb_state_e  state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [W-1:0]  gnt_q, gnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] pick_ptr;
    logic [W-1:0]  pick_gnt;
    logic [IW-1:0] pick_idx;
    logic          pick_any;
    logic          hold;

    // On accept the pointer moves to the current winner in the same cycle,
    // so the pick already uses the new pointer for back-to-back grants.
    assign pick_ptr = (state_q == GNT) ? idx_q : ptr_q;

    p_rr_1hot_pick #(.W(W)) u_pick (
        .i_req (i_req),
        .i_ptr (pick_ptr),
        .o_gnt (pick_gnt),
        .o_idx (pick_idx),
        .o_any (pick_any)
    );

`ifdef P_RR_1HOT_ARB_LOCK_EN
    assign hold = i_lock && i_req[idx_q];
`else
    assign hold = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    gnt_d   = pick_gnt;
                    idx_d   = pick_idx;
                    state_d = GNT;
                end
            end
            GNT: begin
                if (i_gnt_rdy && !hold) begin
                    ptr_d = idx_q;
                    if (pick_any) begin
                        gnt_d = pick_gnt;
                        idx_d = pick_idx;
                    end else begin
                        gnt_d   = '0;
                        idx_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= IW'(W - 1);
            gnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
        end
    end

    assign o_gnt_vld = (state_q == GNT);
    assign o_gnt     = gnt_q;
    assign o_gnt_idx = idx_q;

endmodule

// File: tb/tb_p_rr_1hot_arb.sv
// Directed self-checking bench for p_rr_1hot_arb (W=4); the lock section
// runs only when P_RR_1HOT_ARB_LOCK_EN is defined.
module tb_p_rr_1hot_arb;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] i_req = '0;
    logic         i_lock = 1'b0;
    logic         i_gnt_rdy = 1'b0;
    logic         o_gnt_vld;
    logic [W-1:0] o_gnt;
    logic [1:0]   o_gnt_idx;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    p_rr_1hot_arb #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
`ifdef P_RR_1HOT_ARB_LOCK_EN
        .i_lock    (i_lock),
`endif
        .o_gnt_vld (o_gnt_vld),
        .i_gnt_rdy (i_gnt_rdy),
        .o_gnt     (o_gnt),
        .o_gnt_idx (o_gnt_idx)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_gnt(input string tag, input logic vld, input logic [W-1:0] gnt,
                           input logic [1:0] idx);
        chk({tag, ".vld"}, 32'(o_gnt_vld), 32'(vld));
        chk({tag, ".gnt"}, 32'(o_gnt), 32'(gnt));
        chk({tag, ".idx"}, 32'(o_gnt_idx), 32'(idx));
    endtask

    initial begin
        // Reset and first pick
        tick(); tick();
        chk_gnt("reset", 1'b0, 4'b0000, 2'd0);
        rst = 1'b0;
        i_req = 4'b1010;
        tick();
        chk_gnt("first_pick", 1'b1, 4'b0010, 2'd1);
        i_gnt_rdy = 1'b1; i_req = 4'b0000;
        tick();
        chk_gnt("accept_to_idle", 1'b0, 4'b0000, 2'd0);

        // Full rotation from reset pointer
        i_gnt_rdy = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        i_req = 4'b1111; i_gnt_rdy = 1'b1;
        tick(); chk_gnt("rot0", 1'b1, 4'b0001, 2'd0);
        tick(); chk_gnt("rot1", 1'b1, 4'b0010, 2'd1);
        tick(); chk_gnt("rot2", 1'b1, 4'b0100, 2'd2);
        tick(); chk_gnt("rot3", 1'b1, 4'b1000, 2'd3);
        tick(); chk_gnt("rot4", 1'b1, 4'b0001, 2'd0);
        i_req = 4'b0000;
        tick(); chk_gnt("rot_idle", 1'b0, 4'b0000, 2'd0);

        // Backpressure: ptr=0, grant 2 held while requests change
        i_gnt_rdy = 1'b0; i_req = 4'b0100;
        tick(); chk_gnt("bp_grant", 1'b1, 4'b0100, 2'd2);
        i_req = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            tick(); chk_gnt("bp_hold", 1'b1, 4'b0100, 2'd2);
        end
        i_gnt_rdy = 1'b1;
        tick(); chk_gnt("bp_next", 1'b1, 4'b0001, 2'd0);

        // Single requester wins every accept (ptr=0, wraps back to 0)
        tick(); chk_gnt("single", 1'b1, 4'b0001, 2'd0);
        i_req = 4'b0000;
        tick(); chk_gnt("single_idle", 1'b0, 4'b0000, 2'd0);

        // Wrap and idle: winner 3 accepted, then search starts at 0
        i_gnt_rdy = 1'b0; i_req = 4'b1000;
        tick(); chk_gnt("wrap_w3", 1'b1, 4'b1000, 2'd3);
        i_gnt_rdy = 1'b1; i_req = 4'b0000;
        tick(); chk_gnt("wrap_idle", 1'b0, 4'b0000, 2'd0);
        i_gnt_rdy = 1'b0;
        tick(); chk_gnt("wrap_stay", 1'b0, 4'b0000, 2'd0);
        i_req = 4'b1001;
        tick(); chk_gnt("wrap_pick", 1'b1, 4'b0001, 2'd0);

        // Mid-grant reset: get grant 3 presented (ptr becomes 0 on accept)
        i_gnt_rdy = 1'b1; i_req = 4'b1000;
        tick(); chk_gnt("mid_g3", 1'b1, 4'b1000, 2'd3);
        i_gnt_rdy = 1'b0;
        rst = 1'b1;
        tick(); chk_gnt("mid_rst", 1'b0, 4'b0000, 2'd0);
        rst = 1'b0; i_req = 4'b1001;
        tick(); chk_gnt("mid_after", 1'b1, 4'b0001, 2'd0);

`ifdef P_RR_1HOT_ARB_LOCK_EN
        rst = 1'b1; tick(); rst = 1'b0;
        i_req = 4'b0011; i_lock = 1'b1; i_gnt_rdy = 1'b0;
        tick(); chk_gnt("lock_first", 1'b1, 4'b0001, 2'd0);
        i_gnt_rdy = 1'b1;
        tick(); chk_gnt("lock_hold1", 1'b1, 4'b0001, 2'd0);
        tick(); chk_gnt("lock_hold2", 1'b1, 4'b0001, 2'd0);
        i_lock = 1'b0;
        tick(); chk_gnt("lock_release", 1'b1, 4'b0010, 2'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
